// File: rtl/gold_noc_pkg.sv
// Shared NoC definitions: default flit width, VC bit position and output-stage state encoding.
package gold_noc_pkg;

  localparam int NOC_DATA_W = 64;
  localparam int VC_BIT     = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/gold_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves only when a grant is issued.
module gold_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // ptr = 1 means requester 1 has priority on a tie
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ptr <= 1'b0;
    else if (gnt[0]) ptr <= 1'b1;
    else if (gnt[1]) ptr <= 1'b0;
  end

endmodule

// File: rtl/gold_out_arb.sv
// Output arbiter: VC-polarity filtered round-robin between pass-through and local injection
// into a one-entry output register. Grant counters exist only when GOLD_ARB_STATS_EN is defined.
module gold_out_arb
  import gold_noc_pkg::*;
#(
  parameter int DATA_W = NOC_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_v,
  input  logic [DATA_W-1:0] req_d0,
  input  logic [DATA_W-1:0] req_d1,
  output logic [1:0]        req_gnt,
  output logic              out_so,
  output logic [DATA_W-1:0] out_do,
  input  logic              out_ri,
  output logic              polarity
`ifdef GOLD_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

  if (CNT_W < 1 || DATA_W <= VC_BIT) begin : g_param_check
    $error("gold_out_arb: CNT_W must be >= 1 and DATA_W must cover the VC bit");
  end

  out_state_t state, state_nx;
  logic [1:0] elig;
  logic       can_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) polarity <= 1'b0;
    else       polarity <= ~polarity;
  end

  assign elig[0] = req_v[0] && (req_d0[VC_BIT] == polarity);
  assign elig[1] = req_v[1] && (req_d1[VC_BIT] == polarity);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_EMPTY: if (req_gnt != 2'b00) state_nx = ST_FULL;
      ST_FULL:  if (out_ri && req_gnt == 2'b00) state_nx = ST_EMPTY;
      default:  state_nx = ST_EMPTY;
    endcase
  end

  // Reset gates the grant so no requester sees a pop pulse while reset is held
  always_comb begin
    out_so    = (state == ST_FULL);
    can_grant = !reset && ((state == ST_EMPTY) || out_ri);
  end

  gold_rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (elig),
    .en    (can_grant),
    .gnt   (req_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           out_do <= '0;
    else if (req_gnt[0]) out_do <= req_d0;
    else if (req_gnt[1]) out_do <= req_d1;
  end

`ifdef GOLD_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req_gnt[0] && gnt_cnt0 != {CNT_W{1'b1}}) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (req_gnt[1] && gnt_cnt1 != {CNT_W{1'b1}}) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gold_out_arb.sv
// Self-checking bench for gold_out_arb: reference model + scoreboard plus scenario tasks.
module tb_gold_out_arb;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_v;
  logic [DW-1:0] req_d0, req_d1;
  logic [1:0]    req_gnt;
  logic          out_so;
  logic [DW-1:0] out_do;
  logic          out_ri;
  logic          polarity;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src0_q[$], src1_q[$], exp_q[$];
  logic [1:0]    gnt_log[$];
  logic          pol_log[$];
  logic          pop0, pop1;
  logic          m_full, m_ptr, m_pol;

`ifdef GOLD_ARB_STATS_EN
  logic [15:0]   gnt_cnt0, gnt_cnt1;
  logic [1:0]    req_gnt4;
  logic          out_so4, polarity4;
  logic [DW-1:0] out_do4;
  logic [3:0]    gnt_cnt0_4, gnt_cnt1_4;
`endif

  always #5 clk = ~clk;

  gold_out_arb #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_v    (req_v),
    .req_d0   (req_d0),
    .req_d1   (req_d1),
    .req_gnt  (req_gnt),
    .out_so   (out_so),
    .out_do   (out_do),
    .out_ri   (out_ri),
    .polarity (polarity)
`ifdef GOLD_ARB_STATS_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
`endif
  );

`ifdef GOLD_ARB_STATS_EN
  gold_out_arb #(.DATA_W(DW), .CNT_W(4)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .req_v    (req_v),
    .req_d0   (req_d0),
    .req_d1   (req_d1),
    .req_gnt  (req_gnt4),
    .out_so   (out_so4),
    .out_do   (out_do4),
    .out_ri   (out_ri),
    .polarity (polarity4),
    .gnt_cnt0 (gnt_cnt0_4),
    .gnt_cnt1 (gnt_cnt1_4)
  );
`endif

  // Requester model: each source presents its queue head and pops it after a predicted grant
  initial begin
    req_v  = 2'b00;
    req_d0 = '0;
    req_d1 = '0;
    pop0   = 1'b0;
    pop1   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (pop0 && src0_q.size() > 0) void'(src0_q.pop_front());
        if (pop1 && src1_q.size() > 0) void'(src1_q.pop_front());
      end
      pop0   = 1'b0;
      pop1   = 1'b0;
      req_v  = {src1_q.size() > 0, src0_q.size() > 0};
      req_d0 = (src0_q.size() > 0) ? src0_q[0] : '0;
      req_d1 = (src1_q.size() > 0) ? src1_q[0] : '0;
    end
  end

  // Reference model and scoreboard, evaluated mid-cycle when inputs and outputs are settled
  always @(negedge clk) begin
    logic [1:0] elig, mg;
    logic       can;
    if (reset) begin
      m_full = 1'b0;
      m_ptr  = 1'b0;
      m_pol  = 1'b0;
      exp_q.delete();
      pop0 = 1'b0;
      pop1 = 1'b0;
      checks++;
      if (req_gnt !== 2'b00 || out_so !== 1'b0 || polarity !== 1'b0 || out_do !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs got gnt=%b so=%b pol=%b do=%h want 00/0/0/0",
                 req_gnt, out_so, polarity, out_do);
      end
    end else begin
      elig[0] = req_v[0] && (req_d0[0] == m_pol);
      elig[1] = req_v[1] && (req_d1[0] == m_pol);
      can     = !m_full || out_ri;
      mg      = 2'b00;
      if (can) mg = (elig == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : elig;

      checks++;
      if (req_gnt !== mg) begin
        errors++;
        $display("[TB] FAIL sb_grant t=%0t got %b want %b", $time, req_gnt, mg);
      end
      checks++;
      if (out_so !== m_full) begin
        errors++;
        $display("[TB] FAIL sb_out_so t=%0t got %b want %b", $time, out_so, m_full);
      end
      checks++;
      if (polarity !== m_pol) begin
        errors++;
        $display("[TB] FAIL sb_polarity t=%0t got %b want %b", $time, polarity, m_pol);
      end
      if (m_full) begin
        checks++;
        if (exp_q.size() == 0 || out_do !== exp_q[0]) begin
          errors++;
          $display("[TB] FAIL sb_out_do t=%0t got %h want %h", $time, out_do,
                   (exp_q.size() > 0) ? exp_q[0] : '0);
        end
      end

      if (m_full && out_ri && exp_q.size() > 0) void'(exp_q.pop_front());
      if (mg[0]) begin exp_q.push_back(req_d0); pop0 = 1'b1; end
      if (mg[1]) begin exp_q.push_back(req_d1); pop1 = 1'b1; end
      if (req_gnt != 2'b00) begin
        gnt_log.push_back(req_gnt);
        pol_log.push_back(polarity);
      end
      m_full = (mg != 2'b00) || (m_full && !out_ri);
      if (mg[0])      m_ptr = 1'b1;
      else if (mg[1]) m_ptr = 1'b0;
      m_pol = ~m_pol;
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((src0_q.size() > 0 || src1_q.size() > 0 || exp_q.size() > 0 || out_so === 1'b1)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout got %0d cycles want < %0d", n, budget);
    end
  endtask

  task automatic wait_grant(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (req_gnt !== 2'b00) found = 1'b1;
    end
  endtask

  task automatic wait_polarity(input logic want);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (polarity === want) break;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    out_ri = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_so !== 1'b0 || req_gnt !== 2'b00 || polarity !== 1'b0 || out_do !== '0) begin
        errors++;
        $display("[TB] FAIL test_reset got so=%b gnt=%b pol=%b do=%h want 0/00/0/0",
                 out_so, req_gnt, polarity, out_do);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single();
    bit found;
    out_ri = 1'b1;
    src0_q.push_back(64'h0000_0000_0000_00A0);
    wait_grant(8, found);
    checks++;
    if (!found || req_gnt !== 2'b01 || polarity !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_grant got gnt=%b pol=%b want 01/0", req_gnt, polarity);
    end
    @(negedge clk);
    checks++;
    if (out_so !== 1'b1 || out_do !== 64'h0000_0000_0000_00A0) begin
      errors++;
      $display("[TB] FAIL single_data got so=%b do=%h want 1/00000000000000a0", out_so, out_do);
    end
    @(negedge clk);
    checks++;
    if (out_so !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_one_cycle got so=%b want 0", out_so);
    end
  endtask

  task automatic test_alternate();
    int bad_alt = 0;
    int bad_pol = 0;
    gnt_log.delete();
    pol_log.delete();
    out_ri = 1'b1;
    for (int i = 0; i < 6; i++) begin
      src0_q.push_back(64'(i + 1) << 4);
      src1_q.push_back(64'(i + 1) << 8);
    end
    wait_drain(100);
    checks++;
    if (gnt_log.size() != 12) begin
      errors++;
      $display("[TB] FAIL alt_count got %0d want 12", gnt_log.size());
    end
    // Last grant before this test went to req0, so req1 must win the first tie
    checks++;
    if (gnt_log.size() == 0 || gnt_log[0] !== 2'b10) begin
      errors++;
      $display("[TB] FAIL alt_first got %b want 10", (gnt_log.size() > 0) ? gnt_log[0] : 2'b00);
    end
    for (int k = 0; k < gnt_log.size(); k++) begin
      if (pol_log[k] !== 1'b0) bad_pol++;
      if (k > 0 && gnt_log[k] === gnt_log[k-1]) bad_alt++;
    end
    checks++;
    if (bad_alt != 0) begin
      errors++;
      $display("[TB] FAIL alt_repeat got %0d repeated grants want 0", bad_alt);
    end
    checks++;
    if (bad_pol != 0) begin
      errors++;
      $display("[TB] FAIL alt_polarity got %0d grants off polarity 0 want 0", bad_pol);
    end
  endtask

  task automatic test_vc1();
    out_ri = 1'b1;
    wait_polarity(1'b1);
    src1_q.push_back(64'h8000_0000_0000_0001);
    @(negedge clk);
    checks++;
    if (polarity !== 1'b0 || req_v[1] !== 1'b1 || req_gnt !== 2'b00) begin
      errors++;
      $display("[TB] FAIL vc1_wait got pol=%b v=%b gnt=%b want 0/1/00", polarity, req_v[1], req_gnt);
    end
    @(negedge clk);
    checks++;
    if (polarity !== 1'b1 || req_gnt !== 2'b10) begin
      errors++;
      $display("[TB] FAIL vc1_grant got pol=%b gnt=%b want 1/10", polarity, req_gnt);
    end
    wait_drain(20);
  endtask

  task automatic test_stall();
    bit found;
    logic [DW-1:0] fx, fy;
    fx = 64'h0000_0000_0000_0100;
    fy = 64'h0000_0000_0000_0200;
    out_ri = 1'b0;
    src0_q.push_back(fx);
    src1_q.push_back(fy);
    wait_grant(6, found);
    checks++;
    if (!found || req_gnt !== 2'b01) begin
      errors++;
      $display("[TB] FAIL stall_first got gnt=%b want 01", req_gnt);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_so !== 1'b1 || out_do !== fx || req_gnt !== 2'b00) begin
        errors++;
        $display("[TB] FAIL stall_hold got so=%b do=%h gnt=%b want 1/%h/00", out_so, out_do, req_gnt, fx);
      end
    end
    wait_polarity(1'b1);
    @(posedge clk);
    #1 out_ri = 1'b1;
    @(negedge clk);
    checks++;
    if (req_gnt !== 2'b10 || out_so !== 1'b1 || out_do !== fx) begin
      errors++;
      $display("[TB] FAIL stall_release got gnt=%b so=%b do=%h want 10/1/%h", req_gnt, out_so, out_do, fx);
    end
    @(negedge clk);
    checks++;
    if (out_so !== 1'b1 || out_do !== fy) begin
      errors++;
      $display("[TB] FAIL stall_next got so=%b do=%h want 1/%h", out_so, out_do, fy);
    end
    wait_drain(20);
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    out_ri = 1'b1;
    src0_q.push_back(64'h0000_0000_0000_00C0);
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (out_so === 1'b1) seen = 1'b1;
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (!seen || out_so !== 1'b0 || polarity !== 1'b0 || req_gnt !== 2'b00 || out_do !== '0) begin
      errors++;
      $display("[TB] FAIL reset_async got seen=%b so=%b pol=%b gnt=%b do=%h want 1/0/0/00/0",
               seen, out_so, polarity, req_gnt, out_do);
    end
    src0_q.push_back(64'h0000_0000_0000_0D00);
    src1_q.push_back(64'h0000_0000_0000_0E00);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (req_gnt !== 2'b00) begin
        errors++;
        $display("[TB] FAIL reset_no_grant got %b want 00", req_gnt);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_gnt !== 2'b01 || polarity !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_first_grant got gnt=%b pol=%b want 01/0", req_gnt, polarity);
    end
    wait_drain(30);
  endtask

`ifdef GOLD_ARB_STATS_EN
  task automatic test_stats();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    out_ri = 1'b1;
    for (int i = 0; i < 10; i++) src0_q.push_back(64'(i + 1) << 4);
    wait_drain(100);
    for (int i = 0; i < 7; i++) src1_q.push_back(64'(i + 1) << 8);
    wait_drain(100);
    checks++;
    if (gnt_cnt0 !== 16'd10 || gnt_cnt1 !== 16'd7) begin
      errors++;
      $display("[TB] FAIL stats_counts got %0d/%0d want 10/7", gnt_cnt0, gnt_cnt1);
    end
    checks++;
    if (gnt_cnt0_4 !== 4'hA || gnt_cnt1_4 !== 4'h7) begin
      errors++;
      $display("[TB] FAIL stats_counts4 got %h/%h want a/7", gnt_cnt0_4, gnt_cnt1_4);
    end
    for (int i = 0; i < 10; i++) src0_q.push_back(64'(i + 1) << 12);
    wait_drain(100);
    checks++;
    if (gnt_cnt0 !== 16'd20 || gnt_cnt0_4 !== 4'hF) begin
      errors++;
      $display("[TB] FAIL stats_saturate got %0d/%h want 20/f", gnt_cnt0, gnt_cnt0_4);
    end
  endtask
`endif

  initial begin
    reset  = 1'b1;
    out_ri = 1'b1;
    test_reset();
    test_single();
    test_alternate();
    test_vc1();
    test_stall();
    test_reset_mid();
`ifdef GOLD_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
